// File: rtl/uc_ctrl_if.sv
// Fetch/datapath <-> control unit bus for uc_ctrl: instruction and flag in,
// every datapath select, enable and immediate out.
interface uc_ctrl_if;
    logic [15:0] instr;
    logic        zero;
    logic [3:0]  read_addr;
    logic [3:0]  write_addr;
    logic        read_ch;
    logic        rf_we;
    logic        rf_datain;
    logic        result_hl;
    logic        rf_hl;
    logic        write_ch;
    logic        result_ch;
    logic [2:0]  alu_control;
    logic [5:0]  alu_shift;
    logic [31:0] alu_datain;
    logic        stb_o;
    logic        mem_we;
    logic [1:0]  pc_direct_ch;
    logic [1:0]  pc_mux;

    modport master (
        output instr, zero,
        input  read_addr, write_addr, read_ch, rf_we, rf_datain, result_hl,
               rf_hl, write_ch, result_ch, alu_control, alu_shift, alu_datain,
               stb_o, mem_we, pc_direct_ch, pc_mux
    );

    modport slave (
        input  instr, zero,
        output read_addr, write_addr, read_ch, rf_we, rf_datain, result_hl,
               rf_hl, write_ch, result_ch, alu_control, alu_shift, alu_datain,
               stb_o, mem_we, pc_direct_ch, pc_mux
    );
endinterface

// File: rtl/uc_ctrl.sv
// Registered instruction decoder for the 16-bit-instruction CPU (1-cycle latency).
// Define UC_SHIFT_EN to decode opcodes 6/7 as SHL/SHR; otherwise they are NOPs.
module uc_ctrl (
    input  logic      clk,
    input  logic      rst_n,
    uc_ctrl_if.slave  bus
);

    typedef struct packed {
        logic [3:0]  read_addr;
        logic [3:0]  write_addr;
        logic        read_ch;
        logic        rf_we;
        logic        rf_datain;
        logic        result_hl;
        logic        rf_hl;
        logic        write_ch;
        logic        result_ch;
        logic [2:0]  alu_control;
        logic [5:0]  alu_shift;
        logic [31:0] alu_datain;
        logic        stb_o;
        logic        mem_we;
        logic [1:0]  pc_direct_ch;
        logic [1:0]  pc_mux;
    } ctrl_t;

    ctrl_t ctrl_next;
    ctrl_t ctrl_q;

    // Unknown or unlisted opcodes fall to the NOP default, keeping ALU controls clean.
    always_comb begin
        ctrl_next            = '0;
        ctrl_next.read_addr  = bus.instr[7:4];
        ctrl_next.write_addr = bus.instr[11:8];
        case (bus.instr[15:12])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                ctrl_next.read_ch     = 1'b1;
                ctrl_next.rf_we       = 1'b1;
                ctrl_next.alu_control = 3'(bus.instr[15:12] - 4'h1);
            end
`ifdef UC_SHIFT_EN
            4'h6, 4'h7: begin
                ctrl_next.read_ch     = 1'b1;
                ctrl_next.rf_we       = 1'b1;
                ctrl_next.result_ch   = 1'b1;
                ctrl_next.alu_control = bus.instr[12] ? 3'b110 : 3'b101;
                ctrl_next.alu_shift   = {2'b00, bus.instr[3:0]};
            end
`endif
            4'h8, 4'h9: begin
                ctrl_next.rf_we      = 1'b1;
                ctrl_next.rf_datain  = 1'b1;
                ctrl_next.result_hl  = 1'b1;
                ctrl_next.rf_hl      = bus.instr[12];
                ctrl_next.alu_datain = {24'b0, bus.instr[7:0]};
            end
            4'hA: begin
                ctrl_next.read_ch  = 1'b1;
                ctrl_next.stb_o    = 1'b1;
                ctrl_next.write_ch = 1'b1;
                ctrl_next.rf_we    = 1'b1;
            end
            4'hB: begin
                ctrl_next.read_ch = 1'b1;
                ctrl_next.stb_o   = 1'b1;
                ctrl_next.mem_we  = 1'b1;
            end
            4'hC: begin
                ctrl_next.pc_direct_ch = 2'b01;
                ctrl_next.alu_datain   = {{20{bus.instr[11]}}, bus.instr[11:0]};
                ctrl_next.pc_mux       = bus.zero ? 2'b01 : 2'b00;
            end
            4'hD: begin
                ctrl_next.pc_direct_ch = 2'b10;
                ctrl_next.alu_datain   = {{20{bus.instr[11]}}, bus.instr[11:0]};
                ctrl_next.pc_mux       = bus.zero ? 2'b00 : 2'b01;
            end
            4'hE: begin
                ctrl_next.read_ch      = 1'b1;
                ctrl_next.pc_direct_ch = 2'b11;
                ctrl_next.pc_mux       = 2'b10;
            end
            4'hF: begin
                ctrl_next.pc_mux = 2'b11;
            end
            default: begin
                ctrl_next.read_ch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_next;
        end
    end

    assign bus.read_addr    = ctrl_q.read_addr;
    assign bus.write_addr   = ctrl_q.write_addr;
    assign bus.read_ch      = ctrl_q.read_ch;
    assign bus.rf_we        = ctrl_q.rf_we;
    assign bus.rf_datain    = ctrl_q.rf_datain;
    assign bus.result_hl    = ctrl_q.result_hl;
    assign bus.rf_hl        = ctrl_q.rf_hl;
    assign bus.write_ch     = ctrl_q.write_ch;
    assign bus.result_ch    = ctrl_q.result_ch;
    assign bus.alu_control  = ctrl_q.alu_control;
    assign bus.alu_shift    = ctrl_q.alu_shift;
    assign bus.alu_datain   = ctrl_q.alu_datain;
    assign bus.stb_o        = ctrl_q.stb_o;
    assign bus.mem_we       = ctrl_q.mem_we;
    assign bus.pc_direct_ch = ctrl_q.pc_direct_ch;
    assign bus.pc_mux       = ctrl_q.pc_mux;

endmodule

// File: tb/tb_uc_ctrl.sv
// Directed self-checking bench for uc_ctrl; expected vectors are hand-derived
// from the instruction encoding and packed in a fixed field order.
module tb_uc_ctrl;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;

    uc_ctrl_if bus ();

    uc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: wa, ra, read_ch, rf_we, rf_datain, result_hl, rf_hl, write_ch,
    // result_ch, alu_control, alu_shift, alu_datain, stb_o, mem_we, pc_direct_ch, pc_mux
    function automatic logic [61:0] exp_vec(
        input logic [3:0] wa, input logic [3:0] ra,
        input logic rd_ch, input logic we, input logic dsel, input logic hl,
        input logic hsel, input logic wch, input logic rch,
        input logic [2:0] alu, input logic [5:0] sh, input logic [31:0] din,
        input logic stb, input logic mwe, input logic [1:0] pcd, input logic [1:0] pcm);
        return {wa, ra, rd_ch, we, dsel, hl, hsel, wch, rch, alu, sh, din, stb, mwe, pcd, pcm};
    endfunction

    function automatic logic [61:0] obs_vec();
        return {bus.write_addr, bus.read_addr, bus.read_ch, bus.rf_we, bus.rf_datain,
                bus.result_hl, bus.rf_hl, bus.write_ch, bus.result_ch, bus.alu_control,
                bus.alu_shift, bus.alu_datain, bus.stb_o, bus.mem_we, bus.pc_direct_ch,
                bus.pc_mux};
    endfunction

    task automatic applyStimulus(input logic [15:0] instr, input logic zero, input logic rst_val);
        @(negedge clk);
        bus.instr = instr;
        bus.zero  = zero;
        rst_n     = rst_val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [61:0] expected);
        logic [61:0] observed;
        observed = obs_vec();
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        bus.instr = 16'h0000;
        bus.zero  = 1'b0;

        applyStimulus(16'hF0FF, 1'b0, 1'b0);
        checkOutput("reset_c1", '0);
        applyStimulus(16'hF0FF, 1'b1, 1'b0);
        checkOutput("reset_c2", '0);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        checkOutput("nop_after_reset", '0);

        applyStimulus(16'h0F0F, 1'b0, 1'b1);
        checkOutput("nop_0F0F", exp_vec(4'hF, 4'h0, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
        applyStimulus(16'h1F0F, 1'b0, 1'b1);
        checkOutput("add", exp_vec(4'hF, 4'h0, 1,1,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
        applyStimulus(16'h2F0F, 1'b0, 1'b1);
        checkOutput("sub", exp_vec(4'hF, 4'h0, 1,1,0,0,0,0,0, 3'b001, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
        applyStimulus(16'h3F0F, 1'b0, 1'b1);
        checkOutput("and", exp_vec(4'hF, 4'h0, 1,1,0,0,0,0,0, 3'b010, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
        applyStimulus(16'h4F0F, 1'b0, 1'b1);
        checkOutput("or", exp_vec(4'hF, 4'h0, 1,1,0,0,0,0,0, 3'b011, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
        applyStimulus(16'h5F0F, 1'b0, 1'b1);
        checkOutput("xor", exp_vec(4'hF, 4'h0, 1,1,0,0,0,0,0, 3'b100, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));

        applyStimulus(16'h6123, 1'b0, 1'b1);
`ifdef UC_SHIFT_EN
        checkOutput("shl", exp_vec(4'h1, 4'h2, 1,1,0,0,0,0,1, 3'b101, 6'd3, 32'h0, 0,0, 2'b00, 2'b00));
`else
        checkOutput("shl_off", exp_vec(4'h1, 4'h2, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
`endif
        applyStimulus(16'h7125, 1'b0, 1'b1);
`ifdef UC_SHIFT_EN
        checkOutput("shr", exp_vec(4'h1, 4'h2, 1,1,0,0,0,0,1, 3'b110, 6'd5, 32'h0, 0,0, 2'b00, 2'b00));
`else
        checkOutput("shr_off", exp_vec(4'h1, 4'h2, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));
`endif

        applyStimulus(16'h95AB, 1'b0, 1'b1);
        checkOutput("ldh", exp_vec(4'h5, 4'hA, 0,1,1,1,1,0,0, 3'b000, 6'd0, 32'h000000AB, 0,0, 2'b00, 2'b00));
        applyStimulus(16'h8312, 1'b0, 1'b1);
        checkOutput("ldl", exp_vec(4'h3, 4'h1, 0,1,1,1,0,0,0, 3'b000, 6'd0, 32'h00000012, 0,0, 2'b00, 2'b00));

        applyStimulus(16'hCFFE, 1'b1, 1'b1);
        checkOutput("bz_taken", exp_vec(4'hF, 4'hF, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'hFFFFFFFE, 0,0, 2'b01, 2'b01));
        #2 bus.zero = 1'b0;
        #1;
        checkOutput("bz_zero_mid_cycle", exp_vec(4'hF, 4'hF, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'hFFFFFFFE, 0,0, 2'b01, 2'b01));
        applyStimulus(16'hCFFE, 1'b0, 1'b1);
        checkOutput("bz_not_taken", exp_vec(4'hF, 4'hF, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'hFFFFFFFE, 0,0, 2'b01, 2'b00));
        applyStimulus(16'hDFFE, 1'b0, 1'b1);
        checkOutput("bnz_taken", exp_vec(4'hF, 4'hF, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'hFFFFFFFE, 0,0, 2'b10, 2'b01));
        applyStimulus(16'hD123, 1'b1, 1'b1);
        checkOutput("bnz_not_taken", exp_vec(4'h1, 4'h2, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'h00000123, 0,0, 2'b10, 2'b00));

        applyStimulus(16'hB340, 1'b0, 1'b1);
        checkOutput("st", exp_vec(4'h3, 4'h4, 1,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 1,1, 2'b00, 2'b00));
        applyStimulus(16'hB340, 1'b0, 1'b0);
        checkOutput("reset_during_st", '0);
        applyStimulus(16'hA340, 1'b0, 1'b1);
        checkOutput("ld", exp_vec(4'h3, 4'h4, 1,1,0,0,0,1,0, 3'b000, 6'd0, 32'h0, 1,0, 2'b00, 2'b00));
        applyStimulus(16'hE050, 1'b0, 1'b1);
        checkOutput("jmp", exp_vec(4'h0, 4'h5, 1,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b11, 2'b10));

        applyStimulus(16'hF000, 1'b0, 1'b1);
        checkOutput("halt", exp_vec(4'h0, 4'h0, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b11));
        applyStimulus(16'hF000, 1'b1, 1'b1);
        checkOutput("halt_hold", exp_vec(4'h0, 4'h0, 0,0,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b11));
        applyStimulus(16'hF000, 1'b0, 1'b0);
        checkOutput("reset_during_halt", '0);
        applyStimulus(16'h1AB0, 1'b0, 1'b1);
        checkOutput("first_after_release", exp_vec(4'hA, 4'hB, 1,1,0,0,0,0,0, 3'b000, 6'd0, 32'h0, 0,0, 2'b00, 2'b00));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
